// File: rtl/keystone_cfg_ctrl_pkg.sv
// Shared definitions for the keystone configuration controller: FSM states,
// register offsets, AXI response codes and default soft-reset length.
package keystone_cfg_ctrl_pkg;

    localparam int unsigned DATA_W          = 32;
    localparam int unsigned SRST_CYCLES_DEF = 16;

    localparam int unsigned OFS_CTRL   = 32'h00;
    localparam int unsigned OFS_STATUS = 32'h04;
    localparam int unsigned OFS_STAGE  = 32'h10;
    localparam int unsigned OFS_ACTIVE = 32'h40;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        SRST    = 2'd2
    } state_e;

endpackage

// File: rtl/keystone_cfg_ctrl_axil.sv
// AXI4-Lite slave handshake: turns bus transactions into single-cycle
// wr_en/rd_en strobes and holds B/R responses until the master takes them.
module axil_slave_if
    import keystone_cfg_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 7
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] s_axil_awaddr,
    input  logic              s_axil_awvalid,
    output logic              s_axil_awready,
    input  logic [DATA_W-1:0] s_axil_wdata,
    input  logic              s_axil_wvalid,
    output logic              s_axil_wready,
    output logic [1:0]        s_axil_bresp,
    output logic              s_axil_bvalid,
    input  logic              s_axil_bready,
    input  logic [ADDR_W-1:0] s_axil_araddr,
    input  logic              s_axil_arvalid,
    output logic              s_axil_arready,
    output logic [DATA_W-1:0] s_axil_rdata,
    output logic [1:0]        s_axil_rresp,
    output logic              s_axil_rvalid,
    input  logic              s_axil_rready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic [1:0]        wr_resp,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    input  logic [1:0]        rd_resp
);

    logic              bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic              rvalid_q, rvalid_d;
    logic [1:0]        rresp_q, rresp_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    // Address and data must arrive together; a pending response blocks the next one.
    always_comb begin
        wr_en    = s_axil_awvalid && s_axil_wvalid && !bvalid_q;
        wr_addr  = s_axil_awaddr;
        wr_data  = s_axil_wdata;
        rd_en    = s_axil_arvalid && !rvalid_q;
        rd_addr  = s_axil_araddr;

        bvalid_d = bvalid_q;
        bresp_d  = bresp_q;
        rvalid_d = rvalid_q;
        rresp_d  = rresp_q;
        rdata_d  = rdata_q;

        if (wr_en) begin
            bvalid_d = 1'b1;
            bresp_d  = wr_resp;
        end else if (s_axil_bready) begin
            bvalid_d = 1'b0;
        end

        if (rd_en) begin
            rvalid_d = 1'b1;
            rresp_d  = rd_resp;
            rdata_d  = rd_data;
        end else if (s_axil_rready) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
        end else begin
            bvalid_q <= bvalid_d;
            bresp_q  <= bresp_d;
            rvalid_q <= rvalid_d;
            rresp_q  <= rresp_d;
            rdata_q  <= rdata_d;
        end
    end

    assign s_axil_awready = wr_en;
    assign s_axil_wready  = wr_en;
    assign s_axil_bvalid  = bvalid_q;
    assign s_axil_bresp   = bresp_q;
    assign s_axil_arready = rd_en;
    assign s_axil_rvalid  = rvalid_q;
    assign s_axil_rresp   = rresp_q;
    assign s_axil_rdata   = rdata_q;

endmodule

// File: rtl/keystone_cfg_ctrl.sv
// Keystone map configuration controller: staged coefficients are committed to
// the active set on a frame boundary; also provides core enable and soft reset.
module keystone_cfg_ctrl
    import keystone_cfg_ctrl_pkg::*;
#(
    parameter int unsigned NUM_COEF    = 8,
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned SRST_CYCLES = SRST_CYCLES_DEF
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [ADDR_W-1:0]          s_axil_awaddr,
    input  logic                       s_axil_awvalid,
    output logic                       s_axil_awready,
    input  logic [31:0]                s_axil_wdata,
    input  logic                       s_axil_wvalid,
    output logic                       s_axil_wready,
    output logic [1:0]                 s_axil_bresp,
    output logic                       s_axil_bvalid,
    input  logic                       s_axil_bready,
    input  logic [ADDR_W-1:0]          s_axil_araddr,
    input  logic                       s_axil_arvalid,
    output logic                       s_axil_arready,
    output logic [31:0]                s_axil_rdata,
    output logic [1:0]                 s_axil_rresp,
    output logic                       s_axil_rvalid,
    input  logic                       s_axil_rready,
    input  logic                       sof_beat,
    output logic                       sw_en,
    output logic                       sw_rst,
    output logic [NUM_COEF*DATA_W-1:0] map_registers,
    output logic                       commit_done
);

    localparam int unsigned IDX_W = (NUM_COEF > 1) ? $clog2(NUM_COEF) : 1;
    localparam int unsigned CNT_W = (SRST_CYCLES > 1) ? $clog2(SRST_CYCLES) : 1;

    logic              wr_en, rd_en;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic [DATA_W-1:0] wr_data, rd_data;
    logic [1:0]        wr_resp, rd_resp;

    state_e                           state_q, state_d;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic                             enable_q, enable_d;
    logic [15:0]                      frame_q, frame_d;
    logic [NUM_COEF-1:0][DATA_W-1:0]  stage_q, stage_d;
    logic [NUM_COEF-1:0][DATA_W-1:0]  active_q, active_d;
    logic                             sw_rst_q, sw_rst_d;
    logic                             sw_en_q, sw_en_d;
    logic                             commit_done_q, commit_done_d;
    logic                             ctrl_wr, srst_req, commit_req;

    axil_slave_if #(
        .ADDR_W (ADDR_W)
    ) u_axil (
        .clock          (clock),
        .reset          (reset),
        .s_axil_awaddr  (s_axil_awaddr),
        .s_axil_awvalid (s_axil_awvalid),
        .s_axil_awready (s_axil_awready),
        .s_axil_wdata   (s_axil_wdata),
        .s_axil_wvalid  (s_axil_wvalid),
        .s_axil_wready  (s_axil_wready),
        .s_axil_bresp   (s_axil_bresp),
        .s_axil_bvalid  (s_axil_bvalid),
        .s_axil_bready  (s_axil_bready),
        .s_axil_araddr  (s_axil_araddr),
        .s_axil_arvalid (s_axil_arvalid),
        .s_axil_arready (s_axil_arready),
        .s_axil_rdata   (s_axil_rdata),
        .s_axil_rresp   (s_axil_rresp),
        .s_axil_rvalid  (s_axil_rvalid),
        .s_axil_rready  (s_axil_rready),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_resp        (wr_resp),
        .rd_en          (rd_en),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .rd_resp        (rd_resp)
    );

    // Read decode; unmapped addresses return zero data with SLVERR.
    always_comb begin
        rd_data = '0;
        rd_resp = RESP_SLVERR;
        if (rd_addr == ADDR_W'(OFS_CTRL)) begin
            rd_data = {31'd0, enable_q};
            rd_resp = RESP_OKAY;
        end
        if (rd_addr == ADDR_W'(OFS_STATUS)) begin
            rd_data = {frame_q, 14'd0, sw_rst_q, state_q == PENDING};
            rd_resp = RESP_OKAY;
        end
        for (int unsigned i = 0; i < NUM_COEF; i++) begin
            if (rd_addr == ADDR_W'(OFS_STAGE + 4 * i)) begin
                rd_data = stage_q[IDX_W'(i)];
                rd_resp = RESP_OKAY;
            end
            if (rd_addr == ADDR_W'(OFS_ACTIVE + 4 * i)) begin
                rd_data = active_q[IDX_W'(i)];
                rd_resp = RESP_OKAY;
            end
        end
    end

    // Register bank writes and the commit/soft-reset FSM.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        enable_d      = enable_q;
        frame_d       = frame_q;
        stage_d       = stage_q;
        active_d      = active_q;
        commit_done_d = 1'b0;
        wr_resp       = RESP_SLVERR;

        ctrl_wr    = wr_en && (wr_addr == ADDR_W'(OFS_CTRL));
        srst_req   = ctrl_wr && wr_data[1];
        commit_req = ctrl_wr && wr_data[2];

        if (ctrl_wr) begin
            enable_d = wr_data[0];
            wr_resp  = RESP_OKAY;
        end
        for (int unsigned i = 0; i < NUM_COEF; i++) begin
            if (wr_addr == ADDR_W'(OFS_STAGE + 4 * i)) begin
                wr_resp = RESP_OKAY;
                if (wr_en) begin
                    stage_d[IDX_W'(i)] = wr_data;
                end
            end
        end

        if (sof_beat) begin
            frame_d = frame_q + 16'd1;
        end

        // State is still IDLE during the commit-write cycle, so a coincident sof is ignored.
        case (state_q)
            IDLE: begin
                if (commit_req) begin
                    state_d = PENDING;
                end
            end
            PENDING: begin
                if (sof_beat) begin
                    active_d      = stage_q;
                    commit_done_d = 1'b1;
                    state_d       = IDLE;
                end
            end
            SRST: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (srst_req) begin
            state_d       = SRST;
            cnt_d         = CNT_W'(SRST_CYCLES - 1);
            frame_d       = '0;
            active_d      = active_q;
            commit_done_d = 1'b0;
        end

        sw_rst_d = (state_d == SRST);
        sw_en_d  = enable_d && (state_d != SRST);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            enable_q      <= 1'b0;
            frame_q       <= '0;
            stage_q       <= '0;
            active_q      <= '0;
            sw_rst_q      <= 1'b0;
            sw_en_q       <= 1'b0;
            commit_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            enable_q      <= enable_d;
            frame_q       <= frame_d;
            stage_q       <= stage_d;
            active_q      <= active_d;
            sw_rst_q      <= sw_rst_d;
            sw_en_q       <= sw_en_d;
            commit_done_q <= commit_done_d;
        end
    end

    assign sw_rst        = sw_rst_q;
    assign sw_en         = sw_en_q;
    assign commit_done   = commit_done_q;
    assign map_registers = active_q;

endmodule

// File: tb/tb_keystone_cfg_ctrl.sv
// Directed bench for keystone_cfg_ctrl: register access, frame-synchronised
// commit, soft reset, error responses, backpressure and frame-count wrap.
module tb_keystone_cfg_ctrl;

    localparam int unsigned NUM_COEF = 8;
    localparam int unsigned ADDR_W   = 7;

    logic                       clock = 1'b0;
    logic                       reset;
    logic [ADDR_W-1:0]          s_axil_awaddr;
    logic                       s_axil_awvalid;
    logic                       s_axil_awready;
    logic [31:0]                s_axil_wdata;
    logic                       s_axil_wvalid;
    logic                       s_axil_wready;
    logic [1:0]                 s_axil_bresp;
    logic                       s_axil_bvalid;
    logic                       s_axil_bready;
    logic [ADDR_W-1:0]          s_axil_araddr;
    logic                       s_axil_arvalid;
    logic                       s_axil_arready;
    logic [31:0]                s_axil_rdata;
    logic [1:0]                 s_axil_rresp;
    logic                       s_axil_rvalid;
    logic                       s_axil_rready;
    logic                       sof_beat;
    logic                       sw_en;
    logic                       sw_rst;
    logic [NUM_COEF*32-1:0]     map_registers;
    logic                       commit_done;

    int n_vec = 0;
    int n_err = 0;

    keystone_cfg_ctrl #(
        .NUM_COEF    (NUM_COEF),
        .ADDR_W      (ADDR_W),
        .SRST_CYCLES (16)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .s_axil_awaddr  (s_axil_awaddr),
        .s_axil_awvalid (s_axil_awvalid),
        .s_axil_awready (s_axil_awready),
        .s_axil_wdata   (s_axil_wdata),
        .s_axil_wvalid  (s_axil_wvalid),
        .s_axil_wready  (s_axil_wready),
        .s_axil_bresp   (s_axil_bresp),
        .s_axil_bvalid  (s_axil_bvalid),
        .s_axil_bready  (s_axil_bready),
        .s_axil_araddr  (s_axil_araddr),
        .s_axil_arvalid (s_axil_arvalid),
        .s_axil_arready (s_axil_arready),
        .s_axil_rdata   (s_axil_rdata),
        .s_axil_rresp   (s_axil_rresp),
        .s_axil_rvalid  (s_axil_rvalid),
        .s_axil_rready  (s_axil_rready),
        .sof_beat       (sof_beat),
        .sw_en          (sw_en),
        .sw_rst         (sw_rst),
        .map_registers  (map_registers),
        .commit_done    (commit_done)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic wr(input string tag, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                      input logic [1:0] exp_resp);
        int n = 0;
        s_axil_awaddr  = a;
        s_axil_wdata   = d;
        s_axil_awvalid = 1'b1;
        s_axil_wvalid  = 1'b1;
        #1;
        while (!(s_axil_awready && s_axil_wready) && n < 20) begin
            tick();
            n++;
        end
        tick();
        s_axil_awvalid = 1'b0;
        s_axil_wvalid  = 1'b0;
        n = 0;
        while (s_axil_bvalid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk1({tag, "_bvalid"}, s_axil_bvalid, 1'b1);
        chk({tag, "_bresp"}, {30'd0, s_axil_bresp}, {30'd0, exp_resp});
        s_axil_bready = 1'b1;
        tick();
        s_axil_bready = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [ADDR_W-1:0] a, input logic [31:0] exp_data,
                      input logic [1:0] exp_resp);
        int n = 0;
        s_axil_araddr  = a;
        s_axil_arvalid = 1'b1;
        #1;
        while (s_axil_arready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        tick();
        s_axil_arvalid = 1'b0;
        n = 0;
        while (s_axil_rvalid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk1({tag, "_rvalid"}, s_axil_rvalid, 1'b1);
        chk({tag, "_rdata"}, s_axil_rdata, exp_data);
        chk({tag, "_rresp"}, {30'd0, s_axil_rresp}, {30'd0, exp_resp});
        s_axil_rready = 1'b1;
        tick();
        s_axil_rready = 1'b0;
    endtask

    task automatic sof();
        sof_beat = 1'b1;
        tick();
        sof_beat = 1'b0;
    endtask

    initial begin
        int cnt;
        reset          = 1'b1;
        s_axil_awaddr  = '0;
        s_axil_awvalid = 1'b0;
        s_axil_wdata   = '0;
        s_axil_wvalid  = 1'b0;
        s_axil_bready  = 1'b0;
        s_axil_araddr  = '0;
        s_axil_arvalid = 1'b0;
        s_axil_rready  = 1'b0;
        sof_beat       = 1'b0;
        repeat (3) tick();

        // Reset state
        chk1("rst_bvalid", s_axil_bvalid, 1'b0);
        chk1("rst_rvalid", s_axil_rvalid, 1'b0);
        chk1("rst_sw_en", sw_en, 1'b0);
        chk1("rst_sw_rst", sw_rst, 1'b0);
        chk1("rst_commit_done", commit_done, 1'b0);
        chk1("rst_map_zero", |map_registers, 1'b0);
        reset = 1'b0;
        tick();
        rd("rst_status", 7'h04, 32'h0000_0000, 2'b00);
        rd("rst_ctrl", 7'h00, 32'h0000_0000, 2'b00);

        // Basic commit: stage, commit, idle 5 cycles, then sof
        wr("stage0", 7'h10, 32'h1234_5678, 2'b00);
        rd("stage0_rb", 7'h10, 32'h1234_5678, 2'b00);
        wr("commit1", 7'h00, 32'h0000_0005, 2'b00);
        chk1("commit1_sw_en", sw_en, 1'b1);
        rd("commit1_status", 7'h04, 32'h0000_0001, 2'b00);
        repeat (5) tick();
        chk1("pre_sof_map_zero", |map_registers, 1'b0);
        chk1("pre_sof_commit_done", commit_done, 1'b0);
        sof();
        chk1("copy1_commit_done", commit_done, 1'b1);
        chk("copy1_map0", map_registers[31:0], 32'h1234_5678);
        tick();
        chk1("copy1_done_pulse", commit_done, 1'b0);
        rd("active0", 7'h40, 32'h1234_5678, 2'b00);
        rd("copy1_status", 7'h04, 32'h0001_0000, 2'b00);

        // Commit write coinciding with sof: no copy until the following sof
        wr("stage1", 7'h14, 32'hCAFE_F00D, 2'b00);
        s_axil_awaddr  = 7'h00;
        s_axil_wdata   = 32'h0000_0005;
        s_axil_awvalid = 1'b1;
        s_axil_wvalid  = 1'b1;
        sof_beat       = 1'b1;
        #1;
        chk1("same_cyc_awready", s_axil_awready, 1'b1);
        tick();
        s_axil_awvalid = 1'b0;
        s_axil_wvalid  = 1'b0;
        sof_beat       = 1'b0;
        chk1("same_cyc_no_done", commit_done, 1'b0);
        chk("same_cyc_map1", map_registers[63:32], 32'h0000_0000);
        s_axil_bready = 1'b1;
        tick();
        s_axil_bready = 1'b0;
        wr("stage2_pending", 7'h18, 32'hA5A5_0002, 2'b00);
        rd("pending_status", 7'h04, 32'h0002_0001, 2'b00);
        sof();
        chk1("copy2_commit_done", commit_done, 1'b1);
        chk("copy2_map1", map_registers[63:32], 32'hCAFE_F00D);
        chk("copy2_map2", map_registers[95:64], 32'hA5A5_0002);

        // Repeated commit while pending: one copy only
        wr("stage3", 7'h1C, 32'h0000_0033, 2'b00);
        wr("commit3a", 7'h00, 32'h0000_0005, 2'b00);
        wr("commit3b", 7'h00, 32'h0000_0005, 2'b00);
        sof();
        chk1("copy3_commit_done", commit_done, 1'b1);
        chk("copy3_map3", map_registers[127:96], 32'h0000_0033);
        wr("stage3_b", 7'h1C, 32'h0000_0044, 2'b00);
        sof();
        chk1("nocommit_done", commit_done, 1'b0);
        chk("nocommit_map3", map_registers[127:96], 32'h0000_0033);

        // Soft reset while pending cancels the commit
        wr("stage0_b", 7'h10, 32'hDEAD_BEEF, 2'b00);
        wr("commit4", 7'h00, 32'h0000_0005, 2'b00);
        s_axil_awaddr  = 7'h00;
        s_axil_wdata   = 32'h0000_0002;
        s_axil_awvalid = 1'b1;
        s_axil_wvalid  = 1'b1;
        #1;
        tick();
        s_axil_awvalid = 1'b0;
        s_axil_wvalid  = 1'b0;
        chk1("srst_sw_rst", sw_rst, 1'b1);
        chk1("srst_sw_en", sw_en, 1'b0);
        s_axil_bready = 1'b1;
        cnt = 0;
        while (sw_rst === 1'b1 && cnt < 40) begin
            cnt++;
            tick();
        end
        s_axil_bready = 1'b0;
        chk("srst_len", 32'(cnt), 32'd16);
        rd("post_srst_status", 7'h04, 32'h0000_0000, 2'b00);
        sof();
        chk1("post_srst_no_done", commit_done, 1'b0);
        chk("post_srst_map0", map_registers[31:0], 32'h1234_5678);
        rd("post_srst_stage0", 7'h10, 32'hDEAD_BEEF, 2'b00);
        rd("post_srst_frame", 7'h04, 32'h0001_0000, 2'b00);

        // Commit during soft reset is ignored; enable comes back afterwards
        wr("srst2", 7'h00, 32'h0000_0003, 2'b00);
        chk1("srst2_sw_en", sw_en, 1'b0);
        rd("in_srst_status", 7'h04, 32'h0000_0002, 2'b00);
        wr("commit_in_srst", 7'h00, 32'h0000_0005, 2'b00);
        cnt = 0;
        while (sw_rst === 1'b1 && cnt < 40) begin
            cnt++;
            tick();
        end
        chk1("srst2_ended", sw_rst, 1'b0);
        chk1("srst2_sw_en_back", sw_en, 1'b1);
        rd("srst2_status", 7'h04, 32'h0000_0000, 2'b00);

        // Error responses
        rd("unmapped_rd", 7'h08, 32'h0000_0000, 2'b10);
        wr("ro_status_wr", 7'h04, 32'hFFFF_FFFF, 2'b10);
        rd("status_unchanged", 7'h04, 32'h0000_0000, 2'b00);
        wr("ro_active_wr", 7'h40, 32'h0000_0000, 2'b10);
        rd("active0_unchanged", 7'h40, 32'h1234_5678, 2'b00);

        // Backpressure on B: no second write accepted while bvalid holds
        s_axil_awaddr  = 7'h20;
        s_axil_wdata   = 32'h0000_0011;
        s_axil_awvalid = 1'b1;
        s_axil_wvalid  = 1'b1;
        #1;
        tick();
        s_axil_wdata = 32'h0000_0022;
        #1;
        for (int i = 0; i < 10; i++) begin
            chk1("bp_awready", s_axil_awready, 1'b0);
            chk1("bp_bvalid", s_axil_bvalid, 1'b1);
            tick();
        end
        s_axil_awvalid = 1'b0;
        s_axil_wvalid  = 1'b0;
        s_axil_bready  = 1'b1;
        tick();
        s_axil_bready = 1'b0;
        chk1("bp_released", s_axil_bvalid, 1'b0);
        rd("bp_stage4", 7'h20, 32'h0000_0011, 2'b00);

        // Frame count wrap
        sof_beat = 1'b1;
        repeat (65535) tick();
        sof_beat = 1'b0;
        rd("frame_ffff", 7'h04, 32'hFFFF_0000, 2'b00);
        sof();
        rd("frame_wrap", 7'h04, 32'h0000_0000, 2'b00);

        // Reset mid-transaction drops pending responses at once
        s_axil_awaddr  = 7'h24;
        s_axil_wdata   = 32'h0000_0099;
        s_axil_awvalid = 1'b1;
        s_axil_wvalid  = 1'b1;
        #1;
        tick();
        s_axil_awvalid = 1'b0;
        s_axil_wvalid  = 1'b0;
        s_axil_araddr  = 7'h40;
        s_axil_arvalid = 1'b1;
        #1;
        tick();
        s_axil_arvalid = 1'b0;
        chk1("mid_bvalid", s_axil_bvalid, 1'b1);
        chk1("mid_rvalid", s_axil_rvalid, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk1("arst_bvalid", s_axil_bvalid, 1'b0);
        chk1("arst_rvalid", s_axil_rvalid, 1'b0);
        chk1("arst_map_zero", |map_registers, 1'b0);
        chk1("arst_sw_en", sw_en, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
